multi_port_reg_file: RTL and testbench

- Parametrised successor to the 2-read/1-write RegisterFile used by the CPU datapath.
- Generalised in data width, depth, read-port count and write-port count.
- Adds an optional hardwired zero register, a deterministic write-port priority, and a write-collision flag.
- Adds a sequential clear engine that zeroes the array after reset or on request, with a busy handshake. Sits between decode/issue (reads) and writeback (writes).

---
 rtl/multi_port_reg_file.sv | 137 +++++++++++++
 tb/tb_multi_port_reg_file.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_port_reg_file.sv
// Parametrised multi-port register file with a sequential clear engine, highest-index write priority
// and a registered write-collision flag. Optional write-first read forwarding under REGFILE_BYPASS_EN.
module multi_port_reg_file #(
   parameter int DATA_W   = 32,
   parameter int DEPTH    = 32,
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 2,
   parameter int ZERO_REG = 1,
   localparam int IDX_W   = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     rstN,
   input  logic [NUM_RD*IDX_W-1:0]  rdNum,
   output logic [NUM_RD*DATA_W-1:0] rdData,
   input  logic [NUM_WR-1:0]        wrEnable,
   input  logic [NUM_WR*IDX_W-1:0]  wrNum,
   input  logic [NUM_WR*DATA_W-1:0] wrData,
   input  logic                     clrReq,
   output logic                     busy,
   output logic                     wrCollision
);

   typedef enum logic [0:0] {IDLE = 1'b0, CLEAR = 1'b1} state_t;

   state_t             state_r, state_s;
   logic [IDX_W-1:0]   cnt_r, cnt_s;
   logic               coll_r, coll_s;
   logic               busy_s;
   logic [DATA_W-1:0]  mem_r [DEPTH];
   logic [DEPTH-1:0]   we_s;
   logic [DATA_W-1:0]  wd_s [DEPTH];
   logic [DATA_W-1:0]  rd_s [NUM_RD];

   assign busy_s      = (state_r == CLEAR);
   assign busy        = busy_s;
   assign wrCollision = coll_r;

   // Clear-engine next state: sweep every entry once, then return to IDLE
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      case (state_r)
         IDLE: begin
            if (clrReq) begin
               state_s = CLEAR;
               cnt_s   = '0;
            end else begin
               state_s = IDLE;
            end
         end
         CLEAR: begin
            if (cnt_r == IDX_W'(DEPTH - 1)) begin
               state_s = IDLE;
               cnt_s   = '0;
            end else begin
               cnt_s = cnt_r + IDX_W'(1);
            end
         end
         default: begin
            state_s = CLEAR;
            cnt_s   = '0;
         end
      endcase
   end

   // Control registers: FSM state, clear counter and collision flag
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_r <= CLEAR;
         cnt_r   <= '0;
         coll_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         coll_r  <= coll_s;
      end
   end

   // Per-entry write resolution; ports scanned upward so the highest index wins
   always_comb begin
      for (int r = 0; r < DEPTH; r++) begin
         we_s[r] = 1'b0;
         wd_s[r] = '0;
         for (int w = 0; w < NUM_WR; w++) begin
            we_s[r] = (wrEnable[w] && !busy_s && (wrNum[w*IDX_W +: IDX_W] == IDX_W'(r)) &&
                       !((ZERO_REG != 0) && (r == 0))) ? 1'b1 : we_s[r];
            wd_s[r] = (wrEnable[w] && (wrNum[w*IDX_W +: IDX_W] == IDX_W'(r))) ?
                      wrData[w*DATA_W +: DATA_W] : wd_s[r];
         end
      end
   end

   // Collision detect over every port pair, register 0 excluded when hardwired
   always_comb begin
      coll_s = 1'b0;
      for (int i = 0; i < NUM_WR; i++) begin
         for (int j = i + 1; j < NUM_WR; j++) begin
            coll_s = (!busy_s && wrEnable[i] && wrEnable[j] &&
                      (wrNum[i*IDX_W +: IDX_W] == wrNum[j*IDX_W +: IDX_W]) &&
                      !((ZERO_REG != 0) && (wrNum[i*IDX_W +: IDX_W] == IDX_W'(0)))) ? 1'b1 : coll_s;
         end
      end
   end

   // Storage: the clear engine owns the array while busy, otherwise resolved writes commit
   always_ff @(posedge clk) begin
      for (int r = 0; r < DEPTH; r++) begin
         if (busy_s) begin
            if (cnt_r == IDX_W'(r)) begin
               mem_r[r] <= '0;
            end
         end else if (we_s[r]) begin
            mem_r[r] <= wd_s[r];
         end
      end
   end

   // Asynchronous read ports, blanked while clearing
   always_comb begin
      for (int p = 0; p < NUM_RD; p++) begin
         rd_s[p] = busy_s ? '0 : mem_r[rdNum[p*IDX_W +: IDX_W]];
`ifdef REGFILE_BYPASS_EN
         for (int w = 0; w < NUM_WR; w++) begin
            rd_s[p] = (!busy_s && wrEnable[w] &&
                       (wrNum[w*IDX_W +: IDX_W] == rdNum[p*IDX_W +: IDX_W])) ?
                      wrData[w*DATA_W +: DATA_W] : rd_s[p];
         end
`endif
         rd_s[p] = ((ZERO_REG != 0) && (rdNum[p*IDX_W +: IDX_W] == IDX_W'(0))) ? '0 : rd_s[p];
      end
   end

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      assign rdData[p*DATA_W +: DATA_W] = rd_s[p];
   end

endmodule

// File: tb/tb_multi_port_reg_file.sv
// Self-checking bench for multi_port_reg_file: vector table, clear/reset sequences and random traffic
// compared against an array-based reference model.
module tb_multi_port_reg_file;

   localparam int DW = 32;
   localparam int DP = 32;
   localparam int IW = 5;

   logic            clk  = 1'b0;
   logic            rstN = 1'b1;
   logic            clrReq = 1'b0;
   logic [1:0]      we = 2'b00;
   logic [IW-1:0]   wn_a [2];
   logic [DW-1:0]   wd_a [2];
   logic [IW-1:0]   rn_a [2];
   logic [2*IW-1:0] rdNum, wrNum;
   logic [2*DW-1:0] wrData, rdData;
   logic            busy, wrCollision;

   assign rdNum  = {rn_a[1], rn_a[0]};
   assign wrNum  = {wn_a[1], wn_a[0]};
   assign wrData = {wd_a[1], wd_a[0]};

   always #5 clk = ~clk;

   multi_port_reg_file #(.DATA_W(DW), .DEPTH(DP), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1)) dut (
      .clk(clk), .rstN(rstN), .rdNum(rdNum), .rdData(rdData), .wrEnable(we), .wrNum(wrNum),
      .wrData(wrData), .clrReq(clrReq), .busy(busy), .wrCollision(wrCollision));

   // reference model
   logic [DW-1:0] mem_m [DP];
   int            clear_left;
   logic          coll_m;
   int            total = 0;
   int            bad = 0;

   typedef struct {
      logic [1:0]    we;
      logic [IW-1:0] wn0, wn1;
      logic [DW-1:0] wd0, wd1;
      logic [IW-1:0] rn0, rn1;
      logic [DW-1:0] e0, e1;
      logic          ec;
   } vec_t;
   vec_t tbl [15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] exp_rd(input logic [IW-1:0] idx);
      logic [DW-1:0] v;
      if (clear_left > 0 || idx == 5'd0) return 32'd0;
      v = mem_m[idx];
`ifdef REGFILE_BYPASS_EN
      for (int w = 0; w < 2; w++) if (we[w] && wn_a[w] == idx) v = wd_a[w];
`endif
      return v;
   endfunction

   task automatic zero_model();
      for (int i = 0; i < DP; i++) mem_m[i] = 32'd0;
   endtask

   task automatic model_edge();
      int cnt [DP];
      if (!rstN) begin
         clear_left = DP;
         coll_m     = 1'b0;
         zero_model();
      end else if (clear_left > 0) begin
         clear_left--;
         coll_m = 1'b0;
      end else begin
         for (int i = 0; i < DP; i++) cnt[i] = 0;
         for (int w = 0; w < 2; w++) if (we[w]) cnt[wn_a[w]]++;
         coll_m = 1'b0;
         for (int i = 1; i < DP; i++) if (cnt[i] >= 2) coll_m = 1'b1;
         for (int w = 0; w < 2; w++) if (we[w] && wn_a[w] != 5'd0) mem_m[wn_a[w]] = wd_a[w];
         if (clrReq) begin
            zero_model();
            clear_left = DP;
         end
      end
   endtask

   // compare outputs for the current inputs, then advance one clock
   task automatic tick();
      #3;
      chk("busy", {31'd0, busy}, (clear_left > 0) ? 32'd1 : 32'd0);
      chk("rd0", rdData[31:0], exp_rd(rn_a[0]));
      chk("rd1", rdData[63:32], exp_rd(rn_a[1]));
      chk("coll", {31'd0, wrCollision}, {31'd0, coll_m});
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic set_rand();
      we = 2'($urandom_range(0, 3));
      for (int w = 0; w < 2; w++) begin
         wn_a[w] = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
         wd_a[w] = $urandom;
      end
      rn_a[0] = 5'($urandom_range(0, 7));
      rn_a[1] = 5'($urandom);
   endtask

   task automatic count_busy(input string name, input bit rnd_clr);
      int n = 0;
      while (busy && n < 40) begin
         set_rand();
         clrReq = rnd_clr ? 1'($urandom_range(0, 1)) : 1'b0;
         tick();
         n++;
      end
      clrReq = 1'b0;
      chk(name, 32'(n), 32'd32);
   endtask

   task automatic quiet(input logic [IW-1:0] r0, input logic [IW-1:0] r1);
      we = 2'b00; clrReq = 1'b0; rn_a[0] = r0; rn_a[1] = r1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 200us");
      $fatal(1);
   end

   initial begin
      tbl[0]  = '{2'b11, 5'd1,  5'd2,  32'd14,   32'd13,   5'd3,  5'd4,  32'd0,    32'd0,  1'b0};
      tbl[1]  = '{2'b00, 5'd0,  5'd0,  32'd0,    32'd0,    5'd1,  5'd2,  32'd14,   32'd13, 1'b0};
      tbl[2]  = '{2'b11, 5'd5,  5'd5,  32'd10,   32'd99,   5'd1,  5'd2,  32'd14,   32'd13, 1'b0};
      tbl[3]  = '{2'b00, 5'd0,  5'd0,  32'd0,    32'd0,    5'd5,  5'd0,  32'd99,   32'd0,  1'b1};
      tbl[4]  = '{2'b00, 5'd0,  5'd0,  32'd0,    32'd0,    5'd5,  5'd1,  32'd99,   32'd14, 1'b0};
      tbl[5]  = '{2'b11, 5'd0,  5'd0,  32'd15,   32'd15,   5'd5,  5'd2,  32'd99,   32'd13, 1'b0};
      tbl[6]  = '{2'b00, 5'd0,  5'd0,  32'd0,    32'd0,    5'd0,  5'd0,  32'd0,    32'd0,  1'b0};
      tbl[7]  = '{2'b01, 5'd0,  5'd9,  32'd15,   32'd77,   5'd1,  5'd5,  32'd14,   32'd99, 1'b0};
      tbl[8]  = '{2'b00, 5'd0,  5'd0,  32'd0,    32'd0,    5'd0,  5'd9,  32'd0,    32'd0,  1'b0};
      tbl[9]  = '{2'b10, 5'd8,  5'd8,  32'h77,   32'h55,   5'd7,  5'd9,  32'd0,    32'd0,  1'b0};
      tbl[10] = '{2'b00, 5'd0,  5'd0,  32'd0,    32'd0,    5'd8,  5'd31, 32'h55,   32'd0,  1'b0};
      tbl[11] = '{2'b11, 5'd31, 5'd30, 32'd1,    32'd2,    5'd8,  5'd29, 32'h55,   32'd0,  1'b0};
      tbl[12] = '{2'b00, 5'd0,  5'd0,  32'd0,    32'd0,    5'd31, 5'd30, 32'd1,    32'd2,  1'b0};
      tbl[13] = '{2'b11, 5'd12, 5'd12, 32'd3,    32'd4,    5'd31, 5'd30, 32'd1,    32'd2,  1'b0};
      tbl[14] = '{2'b00, 5'd0,  5'd0,  32'd0,    32'd0,    5'd12, 5'd7,  32'd4,    32'd0,  1'b1};

      for (int w = 0; w < 2; w++) begin
         wn_a[w] = 5'd0; wd_a[w] = 32'd0; rn_a[w] = 5'(w);
      end
      zero_model();
      coll_m     = 1'b0;
      clear_left = DP;

      // asynchronous reset
      #1 rstN = 1'b0;
      #2;
      chk("rst_busy", {31'd0, busy}, 32'd1);
      chk("rst_coll", {31'd0, wrCollision}, 32'd0);
      chk("rst_rd0", rdData[31:0], 32'd0);
      chk("rst_rd1", rdData[63:32], 32'd0);
      tick();
      tick();
      rstN = 1'b1;
      count_busy("init_clear_len", 1'b0);
      for (int i = 0; i < DP; i++) begin
         quiet(5'(i), 5'(DP - 1 - i));
         tick();
      end

      // vector table
      for (int i = 0; i < 15; i++) begin
         we = tbl[i].we; clrReq = 1'b0;
         wn_a[0] = tbl[i].wn0; wn_a[1] = tbl[i].wn1;
         wd_a[0] = tbl[i].wd0; wd_a[1] = tbl[i].wd1;
         rn_a[0] = tbl[i].rn0; rn_a[1] = tbl[i].rn1;
         #2;
         chk($sformatf("vec%0d_rd0", i), rdData[31:0], tbl[i].e0);
         chk($sformatf("vec%0d_rd1", i), rdData[63:32], tbl[i].e1);
         chk($sformatf("vec%0d_coll", i), {31'd0, wrCollision}, {31'd0, tbl[i].ec});
         tick();
      end

      // clear request with a same-cycle write, writes during busy dropped
      quiet(5'd7, 5'd6);
      we = 2'b01; wn_a[0] = 5'd7; wd_a[0] = 32'd8;
      tick();
      quiet(5'd7, 5'd1);
      we = 2'b10; wn_a[1] = 5'd6; wd_a[1] = 32'd9; clrReq = 1'b1;
      #2;
      chk("pre_clr_r7", rdData[31:0], 32'd8);
      tick();
      count_busy("req_clear_len", 1'b1);
      quiet(5'd6, 5'd7);
      #2;
      chk("post_clr_r6", rdData[31:0], 32'd0);
      chk("post_clr_r7", rdData[63:32], 32'd0);
      tick();

      // reset in the middle of a clear restarts it
      quiet(5'd1, 5'd2);
      clrReq = 1'b1;
      tick();
      clrReq = 1'b0;
      for (int i = 0; i < 10; i++) begin
         set_rand();
         tick();
      end
      rstN = 1'b0;
      clear_left = DP; coll_m = 1'b0; zero_model();
      #1;
      chk("midrst_busy", {31'd0, busy}, 32'd1);
      tick();
      rstN = 1'b1;
      count_busy("restart_clear_len", 1'b0);

      // same-cycle write/read of $3
      quiet(5'd3, 5'd0);
      we = 2'b01; wn_a[0] = 5'd3; wd_a[0] = 32'd12; wn_a[1] = 5'd20; wd_a[1] = 32'd0;
      #2;
`ifdef REGFILE_BYPASS_EN
      chk("byp_same", rdData[31:0], 32'd12);
`else
      chk("byp_same", rdData[31:0], 32'd0);
`endif
      tick();
      quiet(5'd3, 5'd0);
      #2;
      chk("byp_next", rdData[31:0], 32'd12);
      tick();

      // random traffic against the model
      for (int i = 0; i < 400; i++) begin
         set_rand();
         clrReq = ($urandom_range(0, 49) == 0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
